// File: rtl/cordic_pkg.sv
// cordic_pkg: FSM states and constant generators for the CORDIC atan table and gain.
package cordic_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int PREC = 62;
  function automatic logic [63:0] atan_inv(input logic [63:0] n);
    logic [63:0] p, s;
    p = (64'd1 << PREC) / n;
    s = '0;
    for (int k = 0; p != 0; k++) begin
      s = (k % 2 == 1) ? s - p / 64'(2 * k + 1) : s + p / 64'(2 * k + 1);
      p = p / n / n;
    end
    return s;
  endfunction
  // atan(1) comes from Machin's formula since the plain series barely converges there
  function automatic logic [63:0] atan_lut(input int i, input int frac);
    logic [63:0] v;
    v = (i == 0) ? 64'd4 * atan_inv(64'd5) - atan_inv(64'd239) : atan_inv(64'd1 << i);
    return (v + (64'd1 << (PREC - 1 - frac))) >> (PREC - frac);
  endfunction
  function automatic logic [63:0] k_gain(input int iters, input int frac);
    logic [63:0] q, r, t;
    q = 64'd1 << PREC;
    for (int i = 0; i < iters; i++)
      if (2 * i < PREC) q = q - q / ((64'd1 << (2 * i)) + 64'd1);
    r = '0;
    for (int b = 31; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= q) r = t;
    end
    return (r + (64'd1 << (30 - frac))) >> (31 - frac);
  endfunction
endpackage

// File: rtl/cordic_cosine_seq_if.sv
// cordic_cosine_seq_if: angle request and cos/sin result handshake bundle.
interface cordic_cosine_seq_if #(parameter int WIDTH = 24);
  logic in_valid, in_ready, out_valid, out_ready, out_err;
  logic [WIDTH+1:0] in_angle, out_cos, out_sin;
  modport master (output in_valid, in_angle, out_ready, input in_ready, out_valid, out_cos, out_sin, out_err);
  modport slave (input in_valid, in_angle, out_ready, output in_ready, out_valid, out_cos, out_sin, out_err);
endinterface

// File: rtl/cordic_stage.sv
// cordic_stage: one combinational CORDIC micro-rotation with a run-time shift index.
module cordic_stage import cordic_pkg::*; #(
  parameter int DW = 28,
  parameter int F = 26,
  parameter int ITERATIONS = 16,
  parameter int CW = 5
) (
  input  logic signed [DW-1:0] x,
  input  logic signed [DW-1:0] y,
  input  logic signed [DW-1:0] z,
  input  logic [CW-1:0]        idx,
  output logic signed [DW-1:0] xn,
  output logic signed [DW-1:0] yn,
  output logic signed [DW-1:0] zn
);
  localparam int NT = 2 ** CW;
  logic [DW-1:0] atan [NT];
  logic signed [DW-1:0] xs, ys;
  logic neg;
  for (genvar t = 0; t < NT; t++) begin : g_lut
    localparam logic [63:0] A = (t < ITERATIONS) ? atan_lut(t, F) : 64'd0;
    assign atan[t] = A[DW-1:0];
  end
  always_comb begin
    neg = z[DW-1];
    xs = y >>> idx;
    ys = x >>> idx;
    xn = neg ? x + xs : x - xs;
    yn = neg ? y - ys : y + ys;
    zn = neg ? z + atan[idx] : z - atan[idx];
  end
endmodule

// File: rtl/cordic_cosine_seq.sv
// cordic_cosine_seq: iterative CORDIC cos/sin core, UNROLL rotations per clock.
module cordic_cosine_seq import cordic_pkg::*; #(
  parameter int WIDTH = 24,
  parameter int ITERATIONS = 16,
  parameter int UNROLL = 1,
  parameter int GUARD = 2
) (
  input logic clk,
  input logic reset,
  cordic_cosine_seq_if.slave bus
);
  localparam int DW = WIDTH + 2 + GUARD;
  localparam int F = WIDTH + GUARD;
  localparam int CW = $clog2(ITERATIONS + 1);
  localparam logic [63:0] KV = k_gain(ITERATIONS, F);
  localparam logic signed [DW-1:0] RND = DW'(2 ** (GUARD - 1));
  localparam logic signed [WIDTH+1:0] ONE = {2'b01, {WIDTH{1'b0}}};
  state_t state, state_n;
  logic [CW-1:0] count;
  logic signed [DW-1:0] x, y, z;
  logic signed [DW-1:0] xs [UNROLL+1];
  logic signed [DW-1:0] ys [UNROLL+1];
  logic signed [DW-1:0] zs [UNROLL+1];
  logic [WIDTH+1:0] cos_q, sin_q;
  logic err_q, rdy, cap, last, err_n;
  assign xs[0] = x;
  assign ys[0] = y;
  assign zs[0] = z;
  for (genvar j = 0; j < UNROLL; j++) begin : g_stage
    cordic_stage #(.DW(DW), .F(F), .ITERATIONS(ITERATIONS), .CW(CW)) u_stage (
      .x(xs[j]), .y(ys[j]), .z(zs[j]), .idx(count + CW'(j)),
      .xn(xs[j+1]), .yn(ys[j+1]), .zn(zs[j+1])
    );
  end
  always_comb begin
    rdy = (state == IDLE) || (state == DONE && bus.out_ready);
    cap = rdy && bus.in_valid;
    last = (state == RUN) && ((count + CW'(UNROLL)) == CW'(ITERATIONS));
    err_n = ($signed(bus.in_angle) > ONE) || ($signed(bus.in_angle) < -ONE);
    state_n = cap ? RUN
            : last ? DONE
            : (state == RUN) ? RUN
            : (state == DONE && !bus.out_ready) ? DONE : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
      z <= '0;
      count <= '0;
      cos_q <= '0;
      sin_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (cap) begin
        x <= KV[DW-1:0];
        y <= '0;
        z <= {bus.in_angle, {GUARD{1'b0}}};
        count <= '0;
        err_q <= err_n;
      end else if (state == RUN) begin
        x <= xs[UNROLL];
        y <= ys[UNROLL];
        z <= zs[UNROLL];
        count <= count + CW'(UNROLL);
      end
      if (last) begin
        cos_q <= (WIDTH+2)'((xs[UNROLL] + RND) >>> GUARD);
        sin_q <= (WIDTH+2)'((ys[UNROLL] + RND) >>> GUARD);
      end
    end
  end
  assign bus.in_ready = rdy;
  assign bus.out_valid = (state == DONE);
  assign bus.out_cos = cos_q;
  assign bus.out_sin = sin_q;
  assign bus.out_err = err_q;
endmodule
